road_frame_sched: RTL and testbench

- Game-level controller for the 8x8 LED matrix.
- Owns the 8-row frame buffer and sequences the game: IDLE, RUN and CRASH.
- Scrolls pseudo-random obstacles down at a prescaled rate and moves the player car from debounced left/right buttons.
- Answers the column-address requests of matrix_ctrl with the transposed column byte. It sits between the SC_DEBOUNCE1 instances and matrix_ctrl in BB_SYSTEM.

---
 rtl/road_pkg.sv | 31 +++
 rtl/road_frame_sched_if.sv | 39 +++
 rtl/road_lfsr8.sv | 27 ++
 rtl/road_frame_sched.sv | 143 ++++++++++++++
 tb/tb_road_frame_sched.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/road_pkg.sv
// road_pkg: shared types and helpers for the road game frame scheduler.
//   state_e      - game state encoding (also driven on the state output)
//   ROW_W, ROWS  - frame buffer geometry (8 rows of 8 columns)
//   LFSR_TAPS    - feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   onehot3to8   - column index to one-hot row byte
//   obstacle_row - new top row from the LFSR state (bit 3 = spawn, 2:0 = column)
package road_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StCrash = 2'b10
    } state_e;

    localparam int unsigned ROW_W = 8;
    localparam int unsigned ROWS  = 8;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [ROW_W-1:0] onehot3to8(input logic [2:0] idx);
        logic [ROW_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] obstacle_row(input logic [7:0] lfsr);
        return lfsr[3] ? onehot3to8(lfsr[2:0]) : '0;
    endfunction

endpackage

// File: rtl/road_frame_sched_if.sv
// road_frame_sched_if: button inputs, display column bus and status outputs of the
// frame scheduler.
//   start/left/right - debounced button levels, active high
//   dispAddr         - column address from matrix_ctrl
//   dispData         - column byte back to matrix_ctrl
//   state/score/crash - game status
// slave: the scheduler side; master: the side driving buttons and address.
interface road_frame_sched_if;
    logic       SC_ROADSCHED_start_In;
    logic       SC_ROADSCHED_left_In;
    logic       SC_ROADSCHED_right_In;
    logic [2:0] SC_ROADSCHED_dispAddr_In;
    logic [7:0] SC_ROADSCHED_dispData_Out;
    logic [1:0] SC_ROADSCHED_state_Out;
    logic [7:0] SC_ROADSCHED_score_Out;
    logic       SC_ROADSCHED_crash_Out;

    modport slave (
        input  SC_ROADSCHED_start_In,
        input  SC_ROADSCHED_left_In,
        input  SC_ROADSCHED_right_In,
        input  SC_ROADSCHED_dispAddr_In,
        output SC_ROADSCHED_dispData_Out,
        output SC_ROADSCHED_state_Out,
        output SC_ROADSCHED_score_Out,
        output SC_ROADSCHED_crash_Out
    );

    modport master (
        output SC_ROADSCHED_start_In,
        output SC_ROADSCHED_left_In,
        output SC_ROADSCHED_right_In,
        output SC_ROADSCHED_dispAddr_In,
        input  SC_ROADSCHED_dispData_Out,
        input  SC_ROADSCHED_state_Out,
        input  SC_ROADSCHED_score_Out,
        input  SC_ROADSCHED_crash_Out
    );
endinterface

// File: rtl/road_lfsr8.sv
// road_lfsr8: free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
//   clk        - clock
//   rst_n      - asynchronous active-low reset, loads SEED
//   lfsr_state - current register value; never 0 for a nonzero SEED
module road_lfsr8
    import road_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr_state
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign lfsr_state = lfsr_q;

endmodule

// File: rtl/road_frame_sched.sv
// road_frame_sched: game controller for the 8x8 LED matrix road game.
// Holds the 8-row frame buffer, runs IDLE/RUN/CRASH, scrolls LFSR obstacles on each
// prescaled tick, moves the car on button rising edges and serves transposed column
// bytes to matrix_ctrl.
//   SC_ROADSCHED_CLOCK_50    - system clock
//   SC_ROADSCHED_RESET_InLow - asynchronous active-low reset
//   bus (slave)              - buttons, column address/data, state/score/crash
module road_frame_sched
    import road_pkg::*;
#(
    parameter int unsigned                    PRESCALER_DATAWIDTH = 23,
    parameter logic [PRESCALER_DATAWIDTH-1:0] TICK_DIV            = 23'd5000000,
    parameter logic [7:0]                     LFSR_SEED           = 8'hA5,
    parameter logic [2:0]                     CAR_INIT            = 3'd4
) (
    input logic              SC_ROADSCHED_CLOCK_50,
    input logic              SC_ROADSCHED_RESET_InLow,
    road_frame_sched_if.slave bus
);

    localparam logic [PRESCALER_DATAWIDTH-1:0] TickLast = TICK_DIV - PRESCALER_DATAWIDTH'(1);

    state_e                         state_q, state_d;
    logic [ROW_W-1:0]               row_q [ROWS];
    logic [ROW_W-1:0]               row_d [ROWS];
    logic [ROW_W-1:0]               frame [ROWS];
    logic [2:0]                     car_q, car_d;
    logic [7:0]                     score_q, score_d;
    logic [PRESCALER_DATAWIDTH-1:0] cnt_q, cnt_d;
    logic                           start_q, left_q, right_q;
    logic [7:0]                     disp_q, disp_d;
    logic [1:0]                     state_out_q;
    logic                           crash_q;
    logic [7:0]                     lfsr;
    logic                           start_rise, left_rise, right_rise;
    logic                           collide, tick;

    road_lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk       (SC_ROADSCHED_CLOCK_50),
        .rst_n     (SC_ROADSCHED_RESET_InLow),
        .lfsr_state(lfsr)
    );

    assign start_rise = bus.SC_ROADSCHED_start_In & ~start_q;
    assign left_rise  = bus.SC_ROADSCHED_left_In  & ~left_q;
    assign right_rise = bus.SC_ROADSCHED_right_In & ~right_q;
    assign collide    = (state_q == StRun) && |(row_q[ROWS-1] & onehot3to8(car_q));
    assign tick       = (state_q == StRun) && !collide && (cnt_q == TickLast);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        car_d   = car_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d = StRun;
                    for (int i = 0; i < ROWS; i++) row_d[i] = '0;
                    score_d = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                // A detected collision freezes the game in the same clock it moves to
                // CRASH, so the offending frame is what stays on the display.
                if (collide) begin
                    state_d = StCrash;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + PRESCALER_DATAWIDTH'(1);
                    if (tick) begin
                        for (int i = ROWS - 1; i > 0; i--) row_d[i] = row_q[i-1];
                        row_d[0] = obstacle_row(lfsr);
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end
                    if (left_rise && !right_rise && car_q != 3'd7) begin
                        car_d = car_q + 3'd1;
                    end else if (right_rise && !left_rise && car_q != 3'd0) begin
                        car_d = car_q - 3'd1;
                    end
                end
            end
            StCrash: begin
                if (start_rise) begin
                    state_d = StIdle;
                    for (int i = 0; i < ROWS; i++) row_d[i] = '0;
                    car_d = CAR_INIT;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame as shown: the car is overlaid on the bottom row; IDLE shows only the car.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            frame[r] = (state_q == StIdle) ? '0 : row_q[r];
        end
        frame[ROWS-1] = frame[ROWS-1] | onehot3to8(car_q);
        disp_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            disp_d[ROWS-1-r] = frame[r][~bus.SC_ROADSCHED_dispAddr_In];
        end
    end

    always_ff @(posedge SC_ROADSCHED_CLOCK_50 or negedge SC_ROADSCHED_RESET_InLow) begin
        if (!SC_ROADSCHED_RESET_InLow) begin
            state_q     <= StIdle;
            for (int i = 0; i < ROWS; i++) row_q[i] <= '0;
            car_q       <= CAR_INIT;
            score_q     <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            disp_q      <= '0;
            state_out_q <= 2'b00;
            crash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            car_q       <= car_d;
            score_q     <= score_d;
            cnt_q       <= cnt_d;
            start_q     <= bus.SC_ROADSCHED_start_In;
            left_q      <= bus.SC_ROADSCHED_left_In;
            right_q     <= bus.SC_ROADSCHED_right_In;
            disp_q      <= disp_d;
            // Decoded from the next state so the status flops track state_q exactly.
            state_out_q <= state_d;
            crash_q     <= (state_d == StCrash);
        end
    end

    assign bus.SC_ROADSCHED_dispData_Out = disp_q;
    assign bus.SC_ROADSCHED_state_Out    = state_out_q;
    assign bus.SC_ROADSCHED_score_Out    = score_q;
    assign bus.SC_ROADSCHED_crash_Out    = crash_q;

endmodule

// File: tb/tb_road_frame_sched.sv
// tb_road_frame_sched: self-checking bench for road_frame_sched with a fast tick
// (TICK_DIV=4). A behavioural game model predicts every output each clock.
module tb_road_frame_sched;

    localparam int         TD    = 4;
    localparam logic [7:0] SEED  = 8'h08;
    localparam int         CINIT = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       left  = 1'b0;
    logic       right = 1'b0;
    logic [2:0] addr  = 3'd0;

    always #5 clk = ~clk;

    road_frame_sched_if bus ();

    assign bus.SC_ROADSCHED_start_In    = start;
    assign bus.SC_ROADSCHED_left_In     = left;
    assign bus.SC_ROADSCHED_right_In    = right;
    assign bus.SC_ROADSCHED_dispAddr_In = addr;

    road_frame_sched #(
        .PRESCALER_DATAWIDTH(23),
        .TICK_DIV           (23'd4),
        .LFSR_SEED          (SEED),
        .CAR_INIT           (3'd4)
    ) dut (
        .SC_ROADSCHED_CLOCK_50   (clk),
        .SC_ROADSCHED_RESET_InLow(rst_n),
        .bus                     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Game model: 0 idle, 1 run, 2 crash.
    int         m_state, m_car, m_score, m_cnt;
    logic [7:0] m_rows [8];
    logic [7:0] m_lfsr, m_disp;
    logic       p_s, p_l, p_r;

    typedef struct {
        logic       s, l, r;
        logic [2:0] a;
        logic [7:0] exp_disp;
        logic [1:0] exp_state;
        logic [7:0] exp_score;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
        m_car   = CINIT;
        m_score = 0;
        m_cnt   = 0;
        m_lfsr  = SEED;
        m_disp  = 8'h00;
        p_s = 1'b0; p_l = 1'b0; p_r = 1'b0;
    endtask

    function automatic logic [7:0] model_frame(input int r);
        logic [7:0] f;
        f = (m_state == 0) ? 8'h00 : m_rows[r];
        if (r == 7) f = f | (8'h01 << m_car);
        return f;
    endfunction

    task automatic model_step();
        logic [7:0] d, f;
        logic       rs, rl, rr;
        for (int r = 0; r < 8; r++) begin
            f = model_frame(r);
            d[7-r] = f[7-addr];
        end
        rs = start && !p_s;
        rl = left && !p_l;
        rr = right && !p_r;
        case (m_state)
            0: if (rs) begin
                m_state = 1;
                for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
                m_score = 0;
                m_cnt   = 0;
            end
            1: begin
                if (m_rows[7][m_car]) begin
                    m_state = 2;
                end else begin
                    if (m_cnt == TD - 1) begin
                        m_cnt = 0;
                        for (int i = 7; i > 0; i--) m_rows[i] = m_rows[i-1];
                        m_rows[0] = m_lfsr[3] ? (8'h01 << m_lfsr[2:0]) : 8'h00;
                        if (m_score < 255) m_score++;
                    end else begin
                        m_cnt++;
                    end
                    if (rl && !rr && m_car < 7) m_car++;
                    else if (rr && !rl && m_car > 0) m_car--;
                end
            end
            default: if (rs) begin
                m_state = 0;
                for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
                m_car = CINIT;
            end
        endcase
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_disp = d;
        p_s = start; p_l = left; p_r = right;
    endtask

    // Inputs are set at the falling edge; outputs are compared at the next one.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("disp",  bus.SC_ROADSCHED_dispData_Out, m_disp);
        chk("state", bus.SC_ROADSCHED_state_Out, m_state);
        chk("score", bus.SC_ROADSCHED_score_Out, m_score);
        chk("crash", bus.SC_ROADSCHED_crash_Out, (m_state == 2) ? 1 : 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_disp",  bus.SC_ROADSCHED_dispData_Out, 0);
        chk("rst_state", bus.SC_ROADSCHED_state_Out, 0);
        chk("rst_score", bus.SC_ROADSCHED_score_Out, 0);
        chk("rst_crash", bus.SC_ROADSCHED_crash_Out, 0);
    endtask

    // Called at a falling edge: reset lands between edges and is checked before the
    // next rising edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        start = 1'b0; left = 1'b0; right = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_left();
        left = 1'b1; cycle();
        left = 1'b0; cycle();
    endtask

    task automatic pulse_right();
        right = 1'b1; cycle();
        right = 1'b0; cycle();
    endtask

    task automatic press_start();
        start = 1'b1; cycle();
        start = 1'b0;
    endtask

    initial begin
        int         sc;
        int         tgt;
        logic       pressed;
        logic [7:0] row6;

        // IDLE with car at column 4: only address 3 lights the bottom row (bit 0).
        tbl[0] = '{1'b0, 1'b0, 1'b0, 3'd4, 8'h00, 2'b00, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 3'd3, 8'h01, 2'b00, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 8'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 3'd7, 8'h00, 2'b00, 8'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 3'd3, 8'h01, 2'b00, 8'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 3'd3, 8'h01, 2'b00, 8'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 3'd3, 8'h01, 2'b00, 8'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 2'b00, 8'd0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 3'd3, 8'h01, 2'b00, 8'd0};

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start = tbl[i].s; left = tbl[i].l; right = tbl[i].r; addr = tbl[i].a;
            cycle();
            chk("vec_disp",  bus.SC_ROADSCHED_dispData_Out, tbl[i].exp_disp);
            chk("vec_state", bus.SC_ROADSCHED_state_Out, tbl[i].exp_state);
            chk("vec_score", bus.SC_ROADSCHED_score_Out, tbl[i].exp_score);
        end
        left = 1'b0; right = 1'b0;

        // Start and first tick.
        press_start();
        chk("run_entry", bus.SC_ROADSCHED_state_Out, 1);
        repeat (TD) cycle();
        chk("first_tick_score", bus.SC_ROADSCHED_score_Out, 1);

        // Car saturates at 7 (bottom row bit at address 0).
        repeat (6) pulse_left();
        addr = 3'd0; cycle();
        chk("car_max", int'(bus.SC_ROADSCHED_dispData_Out[0]), 1);
        addr = 3'd1; cycle();
        chk("car_max_nb", int'(bus.SC_ROADSCHED_dispData_Out[0]), 0);

        // Fresh game, car saturates at 0.
        async_reset();
        press_start();
        repeat (9) pulse_right();
        addr = 3'd7; cycle();
        chk("car_min", int'(bus.SC_ROADSCHED_dispData_Out[0]), 1);

        // Simultaneous left and right rises leave the car at 1.
        pulse_left();
        left = 1'b1; right = 1'b1; cycle();
        left = 1'b0; right = 1'b0; cycle();
        addr = 3'd6; cycle();
        chk("car_both", int'(bus.SC_ROADSCHED_dispData_Out[0]), 1);

        // Steer under an obstacle in row 6 until the game crashes.
        pressed = 1'b0;
        for (int n = 0; n < 4000 && m_state != 2; n++) begin
            left = 1'b0; right = 1'b0;
            row6 = m_rows[6];
            if (!pressed && m_state == 1 && row6 != 8'h00 && !row6[m_car]) begin
                tgt = 0;
                for (int b = 0; b < 8; b++) if (row6[b]) tgt = b;
                if (tgt > m_car) left = 1'b1;
                else right = 1'b1;
            end
            pressed = left | right;
            addr = 3'($urandom_range(7));
            cycle();
        end
        left = 1'b0; right = 1'b0;
        chk("crash_state", bus.SC_ROADSCHED_state_Out, 2);
        chk("crash_flag", bus.SC_ROADSCHED_crash_Out, 1);

        // Frozen for 20 ticks' worth of clocks.
        sc = m_score;
        for (int n = 0; n < 20 * TD; n++) begin
            left  = 1'($urandom_range(1));
            right = 1'($urandom_range(1));
            addr  = 3'($urandom_range(7));
            cycle();
        end
        left = 1'b0; right = 1'b0; cycle();
        chk("frozen_score", bus.SC_ROADSCHED_score_Out, sc);

        press_start();
        chk("crash_to_idle", bus.SC_ROADSCHED_state_Out, 0);
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            cycle();
            chk("idle_frame", bus.SC_ROADSCHED_dispData_Out, (a == 3) ? 1 : 0);
        end

        // Random play against the model, with a mid-game asynchronous reset.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) async_reset();
            start = ($urandom_range(15) == 0);
            left  = ($urandom_range(2) == 0);
            right = ($urandom_range(2) == 0);
            addr  = 3'($urandom_range(7));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
